hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core. It drives stall/flush for the IF_ID, ID_EX,
//  EX_MEM and MEM_WB registers and forwarding selects for EX and ID. It also sequences multi-cycle

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_forward_unit.sv | 55 +++++
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the MIPS pipeline hazard controller:
//   - memory-sequencer state encodings (S_IDLE / S_WAIT / S_HALT)
//   - forwarding select encodings for the EX-stage operand muxes
//   - reg_hit(): "source register is written by a later stage" test,
//     with register 0 never considered a hit
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // $0 is hard-wired to zero, so a write to it must never be forwarded.
    function automatic logic reg_hit(input logic [4:0] src,
                                     input logic [4:0] dst,
                                     input logic       we);
        return (src != 5'd0) && we && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_forward_unit
// Purely combinational forwarding selects.
//   RsD, RtD         in  5  source registers in ID
//   RsE, RtE         in  5  source registers in EX
//   WriteRegM/W      in  5  destination registers in MEM / WB
//   RegWriteM/W      in  1  write enables in MEM / WB
//   ForwardAE/BE     out 2  EX operand select (00 regfile, 01 WB, 10 MEM)
//   ForwardAD/BD     out 1  MEM ALUResult to the ID branch comparator
// ----------------------------------------------------------------------------
module hazard_ctrl_forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD
);

    // Operand 0 is the A (rs) path, operand 1 the B (rt) path.
    logic [4:0] src_e [2];
    logic [4:0] src_d [2];
    logic [1:0] fwd_e [2];
    logic       fwd_d [2];

    assign src_e[0] = RsE;
    assign src_e[1] = RtE;
    assign src_d[0] = RsD;
    assign src_d[1] = RtD;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            // MEM is checked first: it holds the younger, more recent value.
            assign fwd_e[gi] = reg_hit(src_e[gi], WriteRegM, RegWriteM) ? FWD_MEM :
                               reg_hit(src_e[gi], WriteRegW, RegWriteW) ? FWD_WB  :
                                                                          FWD_RF;
            assign fwd_d[gi] = reg_hit(src_d[gi], WriteRegM, RegWriteM);
        end
    endgenerate

    assign ForwardAE = fwd_e[0];
    assign ForwardBE = fwd_e[1];
    assign ForwardAD = fwd_d[0];
    assign ForwardBD = fwd_d[1];

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the 5-stage MIPS pipe: stall/flush generation,
// forwarding selects and sequencing of multi-cycle data-memory accesses.
//   CLK                    in  1      rising-edge clock
//   reset                  in  1      asynchronous active-low reset
//   RsD, RtD, RsE, RtE     in  5      source registers in ID / EX
//   WriteRegE/M/W          in  5      destination registers in EX/MEM/WB
//   RegWriteE/M/W          in  1      write enables in EX/MEM/WB
//   MemtoRegE/M            in  1      load in EX / MEM
//   MemWriteM              in  1      store in MEM
//   BranchD                in  1      branch resolved in ID
//   MemReadyM              in  1      data memory completes this cycle
//   StallF/D/E/M           out 1      hold PC / IF_ID / ID_EX / EX_MEM
//   FlushE, FlushW         out 1      bubble into ID_EX / MEM_WB
//   ForwardAE/BE           out 2      EX operand forwarding selects
//   ForwardAD/BD           out 1      ID branch-compare forwarding
//   MemReqM                out 1      data memory request strobe
//   TimeoutErr             out 1      sticky bus-timeout flag
//   StallCount             out CNT_W  saturating count of StallF cycles
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             MemWriteM,
    input  logic             BranchD,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MemReqM,
    output logic             TimeoutErr,
    output logic [CNT_W-1:0] StallCount
);

    // wait_cnt only ever needs to reach TIMEOUT-1.
    localparam int             WCW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    logic [1:0]       state_reg, state_next;
    logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] stall_count_reg;

    logic memacc;
    logic memstall;
    logic halt_now;
    logic freeze;
    logic lwstall;
    logic brstall;
    logic hz_stall;

    hazard_ctrl_forward_unit u_fwd (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD)
    );

    // Load-use: the load in EX produces a register the ID instruction reads.
    assign lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));

    // Branch in ID needs a value that is still an ALU result in EX or a
    // load in MEM; neither can be forwarded to the comparator yet.
    assign brstall = BranchD &&
                     ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

    assign memacc   = MemtoRegM || MemWriteM;
    assign hz_stall = lwstall || brstall;

    // Memory sequencer: next state plus the per-state request/stall terms.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        MemReqM       = 1'b0;
        memstall      = 1'b0;
        halt_now      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                MemReqM = memacc;
                if (memacc && !MemReadyM) begin
                    memstall      = 1'b1;
                    state_next    = S_WAIT;
                    wait_cnt_next = WCW'(1);
                end
            end
            S_WAIT: begin
                MemReqM = 1'b1;
                if (MemReadyM) begin
                    // MEM_WB captures the data on this same edge.
                    state_next    = S_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // The timeout cycle already looks like HALT.
                    halt_now      = 1'b1;
                    state_next    = S_HALT;
                    timeout_next  = 1'b1;
                    wait_cnt_next = '0;
                end else begin
                    memstall      = 1'b1;
                    wait_cnt_next = wait_cnt_reg + WCW'(1);
                end
            end
            S_HALT: begin
                halt_now = 1'b1;
            end
            default: begin
                state_next    = S_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // A frozen pipe masks lw/br stalls: ID_EX is held rather than bubbled,
    // so the load-use check simply re-evaluates once memory releases.
    assign freeze = memstall || halt_now;
    assign StallF = freeze || hz_stall;
    assign StallD = freeze || hz_stall;
    assign StallE = freeze;
    assign StallM = freeze;
    assign FlushW = freeze;
    assign FlushE = !freeze && hz_stall;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= '0;
            timeout_reg     <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
            if (StallF && (stall_count_reg != {CNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    assign TimeoutErr = timeout_reg;
    assign StallCount = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by random traffic; every cycle is compared
// against a behavioural model of the controller built from the rules:
// forwarding/stall equations and a "consecutive stalled cycles" count
// for the memory access with timeout and halt.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       MemWriteM, BranchD, MemReadyM;

    logic             StallF, StallD, StallE, StallM, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD, MemReqM, TimeoutErr;
    logic [CNT_W-1:0] StallCount;

    int errors = 0;
    int checks = 0;

    // Model state
    int m_run;       // consecutive stalled cycles of the current access
    bit m_halted;
    bit m_terr;
    int m_total;
    // Model next state and expected outputs for the current cycle
    int n_run;
    bit n_halted, n_terr;
    int n_total;
    bit e_req, e_frz, e_stallF, e_flushE;
    logic [1:0] e_fae, e_fbe;
    bit e_fad, e_fbd;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchD(BranchD), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MemReqM(MemReqM), .TimeoutErr(TimeoutErr), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
        if (src != 0 && RegWriteM && src == WriteRegM) return 2'b10;
        if (src != 0 && RegWriteW && src == WriteRegW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_run = 0; m_halted = 0; m_terr = 0; m_total = 0;
    endtask

    task automatic model_eval();
        bit memacc, lw, br;
        memacc = MemtoRegM || MemWriteM;
        lw = MemtoRegE && (RtE == RsD || RtE == RtD);
        br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                         (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        n_run = m_run; n_halted = m_halted; n_terr = m_terr;
        if (m_halted) begin
            e_req = 0; e_frz = 1;
        end else if (m_run > 0) begin
            e_req = 1;
            if (MemReadyM) begin
                e_frz = 0; n_run = 0;
            end else if (m_run + 1 == TIMEOUT) begin
                e_frz = 1; n_halted = 1; n_terr = 1; n_run = 0;
            end else begin
                e_frz = 1; n_run = m_run + 1;
            end
        end else begin
            e_req = memacc;
            e_frz = memacc && !MemReadyM;
            n_run = e_frz ? 1 : 0;
        end
        e_stallF = e_frz || lw || br;
        e_flushE = !e_frz && (lw || br);
        n_total  = (e_stallF && m_total < CNT_MAX) ? m_total + 1 : m_total;
        e_fae = exp_fwd_e(RsE);
        e_fbe = exp_fwd_e(RtE);
        e_fad = (RsD != 0) && RegWriteM && (RsD == WriteRegM);
        e_fbd = (RtD != 0) && RegWriteM && (RtD == WriteRegM);
    endtask

    task automatic compare_all();
        check("StallF", 32'(StallF), 32'(e_stallF));
        check("StallD", 32'(StallD), 32'(e_stallF));
        check("StallE", 32'(StallE), 32'(e_frz));
        check("StallM", 32'(StallM), 32'(e_frz));
        check("FlushE", 32'(FlushE), 32'(e_flushE));
        check("FlushW", 32'(FlushW), 32'(e_frz));
        check("ForwardAE", 32'(ForwardAE), 32'(e_fae));
        check("ForwardBE", 32'(ForwardBE), 32'(e_fbe));
        check("ForwardAD", 32'(ForwardAD), 32'(e_fad));
        check("ForwardBD", 32'(ForwardBD), 32'(e_fbd));
        check("MemReqM", 32'(MemReqM), 32'(e_req));
        check("TimeoutErr", 32'(TimeoutErr), 32'(m_terr));
        check("StallCount", 32'(StallCount), 32'(m_total));
    endtask

    task automatic cycle_begin();
        @(negedge CLK);
        model_eval();
        compare_all();
    endtask

    task automatic cycle_end();
        @(posedge CLK);
        m_run = n_run; m_halted = n_halted; m_terr = n_terr; m_total = n_total;
        #1;
    endtask

    // Asynchronous reset pulse well away from any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_StallCount", 32'(StallCount), 32'd0);
        check("rst_TimeoutErr", 32'(TimeoutErr), 32'd0);
        #1;
        reset = 1'b1;
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
        BranchD = 0; MemReadyM = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        model_reset();
        @(posedge CLK); @(posedge CLK); #1;
        $display("step reset");
        check("reset_StallCount", 32'(StallCount), 32'd0);
        check("reset_TimeoutErr", 32'(TimeoutErr), 32'd0);
        check("reset_StallF", 32'(StallF), 32'd0);
        check("reset_MemReqM", 32'(MemReqM), 32'd0);
        reset = 1'b1;

        // 1: load-use stall then WB forwarding to the consumer
        $display("step load_use");
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2; RtD = 7;
        cycle_begin();
        check("t1_StallF", 32'(StallF), 32'd1);
        check("t1_FlushE", 32'(FlushE), 32'd1);
        check("t1_StallE", 32'(StallE), 32'd0);
        cycle_end();
        clear_inputs();
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 2; RsD = 2; RtD = 7;
        cycle_begin();
        check("t1_nostall", 32'(StallF), 32'd0);
        check("t1_req", 32'(MemReqM), 32'd1);
        cycle_end();
        clear_inputs();
        RegWriteW = 1; WriteRegW = 2; RsE = 2; RtE = 7;
        cycle_begin();
        check("t1_ForwardAE", 32'(ForwardAE), 32'd1);
        check("t1_ForwardBE", 32'(ForwardBE), 32'd0);
        cycle_end();

        // 2: forwarding priority and $0
        $display("step forwarding");
        clear_inputs();
        RsE = 5; RtE = 5; RsD = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
        cycle_begin();
        check("t2_AE_mem", 32'(ForwardAE), 32'd2);
        check("t2_BE_mem", 32'(ForwardBE), 32'd2);
        check("t2_AD", 32'(ForwardAD), 32'd1);
        cycle_end();
        clear_inputs();
        RsE = 0; WriteRegM = 0; RegWriteM = 1; RtE = 3; WriteRegW = 3; RegWriteW = 1;
        cycle_begin();
        check("t2_AE_zero", 32'(ForwardAE), 32'd0);
        check("t2_BE_wb", 32'(ForwardBE), 32'd1);
        check("t2_AD_zero", 32'(ForwardAD), 32'd0);
        cycle_end();

        // 3: three not-ready cycles, release on the fourth
        $display("step mem_wait");
        clear_inputs();
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 9; MemReadyM = 0;
        for (int k = 0; k < 3; k++) begin
            cycle_begin();
            check("t3_req", 32'(MemReqM), 32'd1);
            check("t3_StallF", 32'(StallF), 32'd1);
            check("t3_StallM", 32'(StallM), 32'd1);
            check("t3_FlushW", 32'(FlushW), 32'd1);
            check("t3_FlushE", 32'(FlushE), 32'd0);
            cycle_end();
        end
        MemReadyM = 1;
        cycle_begin();
        check("t3_rel_StallM", 32'(StallM), 32'd0);
        check("t3_rel_FlushW", 32'(FlushW), 32'd0);
        check("t3_rel_req", 32'(MemReqM), 32'd1);
        cycle_end();
        clear_inputs();
        cycle_begin();
        check("t3_idle_req", 32'(MemReqM), 32'd0);
        cycle_end();

        // 5: memstall masks lwstall, bubble inserted on release
        $display("step mem_and_lw");
        clear_inputs();
        MemtoRegM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 3; RsD = 3;
        for (int k = 0; k < 2; k++) begin
            cycle_begin();
            check("t5_FlushE", 32'(FlushE), 32'd0);
            check("t5_StallE", 32'(StallE), 32'd1);
            cycle_end();
        end
        MemReadyM = 1;
        cycle_begin();
        check("t5_rel_FlushE", 32'(FlushE), 32'd1);
        check("t5_rel_StallF", 32'(StallF), 32'd1);
        check("t5_rel_StallE", 32'(StallE), 32'd0);
        cycle_end();
        clear_inputs();
        RsD = 3;
        cycle_begin();
        check("t5_once_FlushE", 32'(FlushE), 32'd0);
        cycle_end();

        // 4: timeout -> HALT, counter saturates, reset recovers
        $display("step timeout");
        clear_inputs();
        MemWriteM = 1; MemReadyM = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle_begin();
            check("t4_StallF", 32'(StallF), 32'd1);
            check("t4_FlushW", 32'(FlushW), 32'd1);
            if (i <= TIMEOUT) check("t4_req_wait", 32'(MemReqM), 32'd1);
            else check("t4_req_halt", 32'(MemReqM), 32'd0);
            if (i <= TIMEOUT) check("t4_terr_lo", 32'(TimeoutErr), 32'd0);
            else check("t4_terr_hi", 32'(TimeoutErr), 32'd1);
            if (i == 20) check("t4_saturate", 32'(StallCount), 32'(CNT_MAX));
            cycle_end();
        end
        do_reset();
        clear_inputs();
        cycle_begin();
        check("t4_post_terr", 32'(TimeoutErr), 32'd0);
        check("t4_post_StallF", 32'(StallF), 32'd0);
        cycle_end();

        // 6: async reset in the middle of a wait (wait_cnt=7)
        $display("step reset_mid_wait");
        clear_inputs();
        MemtoRegM = 1; MemReadyM = 0;
        for (int i = 0; i < 7; i++) begin
            cycle_begin();
            cycle_end();
        end
        do_reset();
        clear_inputs();
        cycle_begin();
        check("t6_idle_req", 32'(MemReqM), 32'd0);
        check("t6_idle_StallF", 32'(StallF), 32'd0);
        cycle_end();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = ($urandom_range(0, 3) == 0);
            MemtoRegM = ($urandom_range(0, 3) == 0);
            MemWriteM = ($urandom_range(0, 5) == 0);
            BranchD   = ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle_begin();
            $display("rand %0d stallF=%0b flushE=%0b req=%0b cnt=%0d", i, StallF, FlushE, MemReqM, StallCount);
            cycle_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
